// File: rtl/ysyx_22040175_lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the byte-lane masks that the store path shifts into position.
package ysyx_22040175_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    function automatic logic [7:0] base_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = MASK_B;
            SZ_H:    m = MASK_H;
            SZ_W:    m = MASK_W;
            default: m = MASK_D;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22040175_lsu_align.sv
// Combinational alignment datapath: misalignment detection, store lane
// shift and byte mask, and load lane extraction with sign/zero extension.
module ysyx_22040175_lsu_align
    import ysyx_22040175_lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [2:0]  off_i,
    input  logic        unsigned_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic        misalign_o,
    output logic [63:0] st_wdata_o,
    output logic [7:0]  st_wmask_o,
    output logic [63:0] ld_data_o
);

    logic [5:0]  bit_off;
    logic [63:0] rd_shifted;

    assign bit_off    = {off_i, 3'b000};
    assign st_wdata_o = wdata_i << bit_off;
    assign st_wmask_o = base_mask(size_i) << off_i;
    assign rd_shifted = rdata_i >> bit_off;

    always_comb begin
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_B: misalign_o = 1'b0;
            SZ_H: misalign_o = off_i[0];
            SZ_W: misalign_o = (off_i[1:0] != 2'b00);
            SZ_D: misalign_o = (off_i != 3'b000);
        endcase
    end

    always_comb begin
        ld_data_o = rd_shifted;
        unique case (size_i)
            SZ_B: ld_data_o = unsigned_i ? {56'b0, rd_shifted[7:0]}
                                         : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
            SZ_H: ld_data_o = unsigned_i ? {48'b0, rd_shifted[15:0]}
                                         : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            SZ_W: ld_data_o = unsigned_i ? {32'b0, rd_shifted[31:0]}
                                         : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            SZ_D: ld_data_o = rd_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22040175_lsu.sv
// Multi-cycle load/store unit between EX/MEM and MEM/WB: one outstanding
// access, valid/ready request and response toward data memory.
module ysyx_22040175_lsu
    import ysyx_22040175_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_waddr_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_wmask_o,
    input  logic              mem_rsp_valid_i,
    input  logic              mem_rsp_err_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_wen_o,
    output logic [4:0]        wb_waddr_o,
    output logic [DATA_W-1:0] wb_rdata_o,
    output logic              err_o,
    output logic              stall_o
);

    lsu_state_e        state_q;
    logic              is_store_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic        idle;
    logic [1:0]  al_size;
    logic [2:0]  al_off;
    logic        misalign;
    logic [63:0] st_wdata;
    logic [7:0]  st_wmask;
    logic [63:0] ld_data;

    // The single align instance checks the incoming request while idle and
    // works on the captured fields in every other state.
    assign idle    = (state_q == StIdle);
    assign al_size = idle ? size_i : size_q;
    assign al_off  = idle ? addr_i[2:0] : addr_q[2:0];

    ysyx_22040175_lsu_align u_align (
        .size_i     (al_size),
        .off_i      (al_off),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .rdata_i    (rdata_q),
        .misalign_o (misalign),
        .st_wdata_o (st_wdata),
        .st_wmask_o (st_wmask),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            size_q     <= SZ_B;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        is_store_q <= is_store_i;
                        size_q     <= size_i;
                        unsigned_q <= unsigned_i;
                        addr_q     <= addr_i;
                        wdata_q    <= wdata_i;
                        rd_q       <= rd_waddr_i;
                        rdata_q    <= '0;
                        err_q      <= misalign;
                        state_q    <= misalign ? StDone : StReq;
                    end
                end
                StReq: begin
                    if (mem_req_ready_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rsp_valid_i) begin
                        rdata_q <= mem_rdata_i;
                        err_q   <= mem_rsp_err_i;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are forced low while rst is held, whatever state is current.
    always_comb begin
        logic in_req;
        logic in_done;
        logic load_ok;
        in_req  = ~rst & (state_q == StReq);
        in_done = ~rst & (state_q == StDone);
        load_ok = in_done & ~is_store_q & ~err_q;

        req_ready_o     = ~rst & idle;
        stall_o         = ~rst & ((idle & req_valid_i) | (state_q == StReq) |
                                  (state_q == StWait));
        mem_req_valid_o = in_req;
        mem_we_o        = in_req & is_store_q;
        mem_addr_o      = in_req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
        mem_wdata_o     = (in_req & is_store_q) ? st_wdata : '0;
        mem_wmask_o     = (in_req & is_store_q) ? st_wmask : 8'h00;
        wb_valid_o      = in_done;
        wb_wen_o        = load_ok;
        wb_waddr_o      = in_done ? rd_q : 5'd0;
        wb_rdata_o      = load_ok ? ld_data : '0;
        err_o           = in_done & err_q;
    end

endmodule
